// File: rtl/uart_wb_sequencer_if.sv
// rtl/uart_wb_sequencer_if.sv - Wishbone master bus plus TX/RX byte streams of uart_wb_sequencer
interface uart_wb_sequencer_if;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [1:0]  o_wb_addr;
  logic [31:0] o_wb_data;
  logic [31:0] i_wb_data;
  logic        i_wb_ack;
  logic        i_wb_stall;
  logic        i_tx_valid;
  logic [7:0]  i_tx_data;
  logic        o_tx_ready;
  logic        o_rx_valid;
  logic [7:0]  o_rx_data;
  logic        i_rx_ready;
  logic        o_busy;
  logic        o_err;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
    input  i_wb_data, i_wb_ack, i_wb_stall,
    input  i_tx_valid, i_tx_data,
    output o_tx_ready,
    output o_rx_valid, o_rx_data,
    input  i_rx_ready,
    output o_busy, o_err
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
    output i_wb_data, i_wb_ack, i_wb_stall,
    output i_tx_valid, i_tx_data,
    input  o_tx_ready,
    input  o_rx_valid, o_rx_data,
    output i_rx_ready,
    input  o_busy, o_err
  );
endinterface

// File: rtl/uart_wb_sequencer.sv
// rtl/uart_wb_sequencer.sv - Wishbone master that programs a wbuart and shuttles TX/RX bytes
// through a status-poll loop, sharing the port round-robin between directions.
module uart_wb_sequencer #(
  parameter logic [31:0] INIT_SETUP  = 32'd6,
  parameter int          ACK_TIMEOUT = 16,
  parameter int          TW          = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  uart_wb_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_POLL, S_DECIDE, S_WR_TX, S_RD_RX
  } state_t;

  localparam logic [1:0]    A_SETUP  = 2'd0;
  localparam logic [1:0]    A_STATUS = 2'd1;
  localparam logic [1:0]    A_RXDATA = 2'd2;
  localparam logic [1:0]    A_TXDATA = 2'd3;
  localparam logic [TW-1:0] TMR_LAST = TW'(ACK_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [1:0]    addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          init_done_q, init_done_d;
  logic          tx_full_q, tx_full_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_ready_q, tx_ready_d;
  logic          rx_full_q, rx_full_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          last_rx_q, last_rx_d;
  logic          st_tx_q, st_tx_d;
  logic          st_rx_q, st_rx_d;
  logic          err_q, err_d;

  logic          bus_done;
  logic          bus_to;
  logic          launch;
  logic          l_we;
  logic [1:0]    l_addr;
  logic [31:0]   l_data;
  logic          rx_ok;
  logic          tx_ok;
  logic          unused_rdata;

  assign unused_rdata = ^{bus.i_wb_data[31:17], bus.i_wb_data[15:9]};

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    tmr_d       = tmr_q;
    init_done_d = init_done_q;
    tx_full_d   = tx_full_q;
    tx_byte_d   = tx_byte_q;
    rx_full_d   = rx_full_q;
    rx_byte_d   = rx_byte_q;
    last_rx_d   = last_rx_q;
    st_tx_d     = st_tx_q;
    st_rx_d     = st_rx_q;
    err_d       = err_q;
    bus_done    = 1'b0;
    bus_to      = 1'b0;
    launch      = 1'b0;
    l_we        = 1'b0;
    l_addr      = A_SETUP;
    l_data      = 32'd0;
    rx_ok       = st_rx_q & ~rx_full_q;
    tx_ok       = st_tx_q & tx_full_q;

    // Single outstanding transfer: stb drops once accepted, the timer only runs after that.
    if (cyc_q) begin
      if (stb_q && !bus.i_wb_stall) begin
        stb_d = 1'b0;
        tmr_d = '0;
      end
      if (bus.i_wb_ack) begin
        bus_done = 1'b1;
      end else if (!stb_q) begin
        if (tmr_q == TMR_LAST) bus_to = 1'b1;
        else                   tmr_d  = tmr_q + 1'b1;
      end
      if (bus_done || bus_to) begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
      end
    end

    if (tx_ready_q && bus.i_tx_valid) begin
      tx_full_d = 1'b1;
      tx_byte_d = bus.i_tx_data;
    end
    if (rx_full_q && bus.i_rx_ready) rx_full_d = 1'b0;

    case (state_q)
      S_INIT: begin
        if (!cyc_q) begin
          launch = 1'b1;
          l_we   = 1'b1;
          l_addr = A_SETUP;
          l_data = INIT_SETUP;
        end else if (bus_done || bus_to) begin
          init_done_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_IDLE: begin
        if (tx_full_q || !rx_full_q) begin
          launch  = 1'b1;
          l_addr  = A_STATUS;
          state_d = S_POLL;
        end
      end
      S_POLL: begin
        if (bus_done) begin
          st_tx_d = bus.i_wb_data[0];
          st_rx_d = bus.i_wb_data[16];
          state_d = S_DECIDE;
        end else if (bus_to) begin
          state_d = S_IDLE;
        end
      end
      S_DECIDE: begin
        // When both directions are ready, the one not served last goes first.
        if (rx_ok && (!tx_ok || !last_rx_q)) begin
          launch  = 1'b1;
          l_addr  = A_RXDATA;
          state_d = S_RD_RX;
        end else if (tx_ok) begin
          launch  = 1'b1;
          l_we    = 1'b1;
          l_addr  = A_TXDATA;
          l_data  = {24'd0, tx_byte_q};
          state_d = S_WR_TX;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_TX: begin
        if (bus_done || bus_to) begin
          tx_full_d = 1'b0;
          state_d   = S_IDLE;
          if (bus_done) last_rx_d = 1'b0;
        end
      end
      S_RD_RX: begin
        if (bus_done) begin
          last_rx_d = 1'b1;
          if (!bus.i_wb_data[8]) begin
            rx_full_d = 1'b1;
            rx_byte_d = bus.i_wb_data[7:0];
          end
          state_d = S_IDLE;
        end else if (bus_to) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase

    if (launch) begin
      cyc_d   = 1'b1;
      stb_d   = 1'b1;
      we_d    = l_we;
      addr_d  = l_addr;
      wdata_d = l_data;
      tmr_d   = '0;
    end
    if (bus_to) err_d = 1'b1;
    tx_ready_d = init_done_d & ~tx_full_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_INIT;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 2'd0;
      wdata_q     <= 32'd0;
      tmr_q       <= '0;
      init_done_q <= 1'b0;
      tx_full_q   <= 1'b0;
      tx_byte_q   <= 8'd0;
      tx_ready_q  <= 1'b0;
      rx_full_q   <= 1'b0;
      rx_byte_q   <= 8'd0;
      last_rx_q   <= 1'b0;
      st_tx_q     <= 1'b0;
      st_rx_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      tmr_q       <= tmr_d;
      init_done_q <= init_done_d;
      tx_full_q   <= tx_full_d;
      tx_byte_q   <= tx_byte_d;
      tx_ready_q  <= tx_ready_d;
      rx_full_q   <= rx_full_d;
      rx_byte_q   <= rx_byte_d;
      last_rx_q   <= last_rx_d;
      st_tx_q     <= st_tx_d;
      st_rx_q     <= st_rx_d;
      err_q       <= err_d;
    end
  end

  assign bus.o_wb_cyc   = cyc_q;
  assign bus.o_wb_stb   = stb_q;
  assign bus.o_wb_we    = we_q;
  assign bus.o_wb_addr  = addr_q;
  assign bus.o_wb_data  = wdata_q;
  assign bus.o_tx_ready = tx_ready_q;
  assign bus.o_rx_valid = rx_full_q;
  assign bus.o_rx_data  = rx_byte_q;
  assign bus.o_busy     = cyc_q;
  assign bus.o_err      = err_q;

endmodule
